// File: rtl/bullet_if.sv
// Bullet controller signal bundle: game-side inputs and bullet position/status outputs.
interface bullet_if;
  localparam int unsigned XW = 10;
  localparam int unsigned YW = 10;

  logic          frame_tick;
  logic          fire;
  logic [XW-1:0] gunx;
  logic          col;
  logic [XW-1:0] bulletx;
  logic [YW-1:0] bullety;
  logic          active;
  logic          hit_pulse;

  modport master (
    output frame_tick, fire, gunx, col,
    input  bulletx, bullety, active, hit_pulse
  );

  modport slave (
    input  frame_tick, fire, gunx, col,
    output bulletx, bullety, active, hit_pulse
  );
endinterface

// File: rtl/bullet_ctrl.sv
// Player bullet generator: launches one bullet on a fire press and moves it up
// once per frame tick until it hits something or leaves the top of the screen.
module bullet_ctrl #(
  parameter int unsigned SCREEN_W   = 640,
  parameter int unsigned GUN_Y      = 440,
  parameter int unsigned GUN_OFFSET = 15,
  parameter int unsigned STEP       = 8,
  parameter int unsigned COOLDOWN   = 4,
  parameter int unsigned PARK_Y     = 1023
) (
  input  logic     clk,
  input  logic     rst,
  bullet_if.slave  bus
);

  localparam int unsigned XW = 10;
  localparam int unsigned YW = 10;
  localparam int unsigned SW = XW + 1;
  localparam int unsigned CW = $clog2(COOLDOWN + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FLY  = 2'd1,
    HIT  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          fire_q;
  logic [CW-1:0] cooldown_q, cooldown_d;
  logic [XW-1:0] bulletx_q, bulletx_d;
  logic [YW-1:0] bullety_q, bullety_d;
  logic          active_q, active_d;
  logic          hit_pulse_q, hit_pulse_d;

  logic          fire_rise_c;
  logic [SW-1:0] launch_sum_c;
  logic [XW-1:0] launch_x_c;

  assign fire_rise_c  = bus.fire & ~fire_q;
  // Muzzle position computed one bit wider so it saturates rather than wraps.
  assign launch_sum_c = SW'(bus.gunx) + SW'(GUN_OFFSET);
  assign launch_x_c   = (launch_sum_c > SW'(SCREEN_W - 1)) ? XW'(SCREEN_W - 1)
                                                           : launch_sum_c[XW-1:0];

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      fire_q      <= 1'b1;
      cooldown_q  <= '0;
      bulletx_q   <= '0;
      bullety_q   <= YW'(PARK_Y);
      active_q    <= 1'b0;
      hit_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fire_q      <= bus.fire;
      cooldown_q  <= cooldown_d;
      bulletx_q   <= bulletx_d;
      bullety_q   <= bullety_d;
      active_q    <= active_d;
      hit_pulse_q <= hit_pulse_d;
    end
  end

  // Next-state logic; col outranks frame_tick while flying.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (fire_rise_c && (cooldown_q == '0)) state_d = FLY;
      end
      FLY: begin
        if (bus.col)                                        state_d = HIT;
        else if (bus.frame_tick && (bullety_q < YW'(STEP))) state_d = IDLE;
      end
      HIT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and cooldown counter.
  always_comb begin
    cooldown_d  = cooldown_q;
    bulletx_d   = bulletx_q;
    bullety_d   = bullety_q;
    active_d    = active_q;
    hit_pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (cooldown_q != '0) begin
          if (bus.frame_tick) cooldown_d = cooldown_q - CW'(1);
        end else if (fire_rise_c) begin
          active_d  = 1'b1;
          bullety_d = YW'(GUN_Y);
          bulletx_d = launch_x_c;
        end
      end
      FLY: begin
        if (!bus.col && bus.frame_tick) begin
          if (bullety_q < YW'(STEP)) begin
            active_d   = 1'b0;
            bullety_d  = YW'(PARK_Y);
            cooldown_d = CW'(COOLDOWN);
          end else begin
            bullety_d = bullety_q - YW'(STEP);
          end
        end
      end
      HIT: begin
        hit_pulse_d = 1'b1;
        active_d    = 1'b0;
        bullety_d   = YW'(PARK_Y);
        cooldown_d  = CW'(COOLDOWN);
      end
      default: begin
        active_d  = 1'b0;
        bullety_d = YW'(PARK_Y);
      end
    endcase
  end

  assign bus.bulletx   = bulletx_q;
  assign bus.bullety   = bullety_q;
  assign bus.active    = active_q;
  assign bus.hit_pulse = hit_pulse_q;

endmodule

// File: tb/tb_bullet_ctrl.sv
// Bench for bullet_ctrl: directed scenarios plus randomized traffic, every cycle
// compared against a flight-level reference model.
module tb_bullet_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  // Reference model: bullet described by its flight, not by controller states.
  bit   m_in_air;
  bit   m_hit_due;
  bit   m_hit;
  bit   m_prev_fire;
  int   m_x;
  int   m_y;
  int   m_cool;

  bullet_if bus ();

  bullet_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit t, input bit f, input int g, input bit c);
    bit rise;
    if (r) begin
      m_in_air = 0; m_hit_due = 0; m_hit = 0; m_prev_fire = 1;
      m_x = 0; m_y = 1023; m_cool = 0;
      return;
    end
    rise        = f && !m_prev_fire;
    m_prev_fire = f;
    m_hit       = 0;
    if (m_hit_due) begin
      m_hit_due = 0; m_hit = 1; m_in_air = 0; m_y = 1023; m_cool = 4;
    end else if (m_in_air) begin
      if (c) m_hit_due = 1;
      else if (t) begin
        if (m_y - 8 < 0) begin
          m_in_air = 0; m_y = 1023; m_cool = 4;
        end else begin
          m_y = m_y - 8;
        end
      end
    end else if (m_cool > 0) begin
      if (t) m_cool--;
    end else if (rise) begin
      m_in_air = 1;
      m_y      = 440;
      m_x      = (g + 15 > 639) ? 639 : g + 15;
    end
  endtask

  // One clock: drive inputs, advance the model, compare all outputs just after the edge.
  task automatic step(input bit r, input bit t, input bit f, input int g, input bit c);
    rst            = r;
    bus.frame_tick = t;
    bus.fire       = f;
    bus.gunx       = 10'(g);
    bus.col        = c;
    @(posedge clk);
    model_edge(r, t, f, g, c);
    #1;
    check_val("active", int'(bus.active), int'(m_in_air || m_hit_due));
    check_val("bullety", int'(bus.bullety), m_y);
    check_val("bulletx", int'(bus.bulletx), m_x);
    check_val("hit_pulse", int'(bus.hit_pulse), int'(m_hit));
  endtask

  task automatic ticks(input int n, input int g);
    for (int i = 0; i < n; i++) begin
      step(0, 1, 0, g, 0);
      step(0, 0, 0, g, 0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_prev_fire = 1; m_in_air = 0; m_hit_due = 0; m_hit = 0;
    m_x = 0; m_y = 1023; m_cool = 0;
    rst = 1; bus.frame_tick = 0; bus.fire = 1; bus.gunx = '0; bus.col = 0;

    // Fire held through reset must not launch until released and pressed again.
    step(1, 0, 1, 100, 0);
    step(1, 0, 1, 100, 0);
    check_val("rst_bullety", int'(bus.bullety), 1023);
    check_val("rst_bulletx", int'(bus.bulletx), 0);
    step(0, 0, 1, 100, 0);
    step(0, 1, 1, 100, 0);
    check_val("held_fire_no_launch", int'(bus.active), 0);
    step(0, 0, 0, 100, 0);
    step(0, 0, 1, 100, 0);
    check_val("launch_active", int'(bus.active), 1);
    check_val("launch_x", int'(bus.bulletx), 115);
    check_val("launch_y", int'(bus.bullety), 440);
    step(0, 0, 0, 100, 0);
    ticks(3, 200);
    check_val("y_after_3", int'(bus.bullety), 416);
    check_val("x_latched", int'(bus.bulletx), 115);

    // Natural miss after 56 ticks, then 4-tick cooldown blocks presses.
    ticks(52, 200);
    check_val("y_at_top", int'(bus.bullety), 0);
    step(0, 1, 0, 200, 0);
    check_val("miss_active", int'(bus.active), 0);
    check_val("miss_y", int'(bus.bullety), 1023);
    check_val("miss_no_hit", int'(bus.hit_pulse), 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 200, 0);
      check_val("cooldown_block", int'(bus.active), 0);
      step(0, 1, 0, 200, 0);
    end
    step(0, 0, 1, 200, 0);
    check_val("post_cooldown_launch", int'(bus.active), 1);
    step(0, 0, 0, 200, 0);

    // Col beats frame_tick; hit_pulse lasts one cycle.
    ticks(30, 200);
    check_val("y_200", int'(bus.bullety), 200);
    step(0, 1, 0, 200, 1);
    check_val("col_y_hold", int'(bus.bullety), 200);
    step(0, 0, 0, 200, 0);
    check_val("hit_pulse_on", int'(bus.hit_pulse), 1);
    check_val("hit_park", int'(bus.bullety), 1023);
    step(0, 0, 0, 200, 0);
    check_val("hit_pulse_off", int'(bus.hit_pulse), 0);

    // Idle col ignored; saturation at right edge; fire ignored mid-flight.
    step(0, 0, 0, 630, 1);
    check_val("idle_col_no_hit", int'(bus.hit_pulse), 0);
    ticks(4, 630);
    step(0, 0, 1, 630, 0);
    check_val("sat_x", int'(bus.bulletx), 639);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 300, 0);
      step(0, 1, 1, 300, 0);
    end
    check_val("no_relaunch_y", int'(bus.bullety), 400);
    step(0, 0, 0, 300, 0);
    ticks(13, 300);
    check_val("y_296", int'(bus.bullety), 296);

    // Reset mid-flight clears everything, including cooldown.
    step(1, 0, 0, 300, 0);
    check_val("rst_fly_active", int'(bus.active), 0);
    check_val("rst_fly_x", int'(bus.bulletx), 0);
    check_val("rst_fly_y", int'(bus.bullety), 1023);
    step(0, 0, 0, 50, 0);
    step(0, 0, 1, 50, 0);
    check_val("rst_no_cooldown", int'(bus.active), 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 6000; i++) begin
      step(($urandom_range(0, 799) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) == 0),
           int'($urandom_range(0, 1023)),
           ($urandom_range(0, 59) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
